// File: rtl/pe_reduce_if.sv
// Beat-level handshake bundle for pe_reduce: input beat with sideband, output result.
interface pe_reduce_if #(
    parameter int N_LANES = 16,
    parameter int W_IN    = 16,
    parameter int W_OUT   = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N_LANES*W_IN-1:0]   in_data;
    logic [N_LANES-1:0]        in_mask;
    logic [1:0]                mode;
    logic                      fb_enable;
    logic [W_OUT-1:0]          fb_data;
    logic                      acc_last;
    logic [1:0]                nl_type;
    logic                      out_valid;
    logic                      out_ready;
    logic [W_OUT-1:0]          out_data;
    logic                      out_sat;
    logic                      busy;

    modport master (
        output in_valid, in_data, in_mask, mode, fb_enable, fb_data, acc_last, nl_type, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );
    modport slave (
        input  in_valid, in_data, in_mask, mode, fb_enable, fb_data, acc_last, nl_type, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/pe_reduce.sv
// Pipelined lane reduction (sum / dense accumulate / max) with feedback, saturation and
// nonlinearity. One global advance enable stalls every stage together.
module pe_reduce_node #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic                i_max,
    output logic signed [W-1:0] o_y
);
    assign o_y = i_max ? ((i_a > i_b) ? i_a : i_b) : (i_a + i_b);
endmodule

module pe_reduce #(
    parameter int N_LANES = 16,
    parameter int W_IN    = 16,
    parameter int W_ACC   = 32,
    parameter int W_OUT   = 16,
    parameter int FRAC    = 0
) (
    input logic         clk,
    input logic         rst,
    pe_reduce_if.slave  bus
);
    localparam int L    = $clog2(N_LANES);
    localparam int NT   = 2*N_LANES - 1;

    localparam logic signed [W_ACC-1:0] ACC_NEG = {1'b1, {(W_ACC-1){1'b0}}};
    localparam logic signed [W_ACC+1:0] ACC_HI  = {3'b000, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC+1:0] ACC_LO  = {3'b111, {(W_ACC-1){1'b0}}};
    localparam logic signed [W_ACC+1:0] OUT_HI  = {{(W_ACC+3-W_OUT){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_ACC+1:0] OUT_LO  = {{(W_ACC+3-W_OUT){1'b1}}, {(W_OUT-1){1'b0}}};

    typedef struct packed {
        logic [1:0]              mode;
        logic                    fb_en;
        logic signed [W_OUT-1:0] fb_data;
        logic                    last;
        logic [1:0]              nl;
        logic                    allm;
    } side_t;

    // Tree level of entry j: leaves 0..N-1, then each level packed after the previous one.
    function automatic int lvl_of(input int j);
        int base, n, k;
        base = 0; n = N_LANES; k = 0;
        while (j >= base + n) begin
            base += n; n = n >> 1; k++;
        end
        return k;
    endfunction

    logic                     w_en;
    logic                     w_in_max;
    side_t                    w_side_in;
    logic signed [W_ACC-1:0]  w_nxt  [NT];
    logic signed [W_ACC-1:0]  r_tree [NT];
    side_t                    r_side [L+1];
    logic [L:0]               r_vld_pipe;

    logic                     r_ov;
    logic signed [W_OUT-1:0]  r_od;
    logic                     r_os;
    logic signed [W_ACC-1:0]  r_acc;
    logic                     r_pend;

    assign w_en          = !r_ov || bus.out_ready;
    assign bus.in_ready  = w_en && !rst;
    assign w_in_max      = (bus.mode == 2'd2);

    always_comb begin
        w_side_in         = '0;
        w_side_in.mode    = bus.mode;
        w_side_in.fb_en   = bus.fb_enable;
        w_side_in.fb_data = bus.fb_data;
        w_side_in.last    = bus.acc_last;
        w_side_in.nl      = bus.nl_type;
        w_side_in.allm    = ~|bus.in_mask;
    end

    // Masked lanes become the identity of the beat's reduction: 0 for sums, most-negative for max.
    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        logic signed [W_IN-1:0] w_x;
        assign w_x = bus.in_data[j*W_IN +: W_IN];
        assign w_nxt[j] = bus.in_mask[j] ? W_ACC'(w_x) : (w_in_max ? ACC_NEG : '0);
    end

    for (genvar j = N_LANES; j < NT; j++) begin : g_node
        localparam int LV = lvl_of(j);
        pe_reduce_node #(.W(W_ACC)) u_node (
            .i_a   (r_tree[2*(j-N_LANES)]),
            .i_b   (r_tree[2*(j-N_LANES)+1]),
            .i_max (r_side[LV-1].mode == 2'd2),
            .o_y   (w_nxt[j])
        );
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_tree    <= w_nxt;
            r_side[0] <= w_side_in;
            for (int k = 1; k <= L; k++) r_side[k] <= r_side[k-1];
        end
    end

    // Post stage
    side_t                    w_ps;
    logic                     w_is_sum, w_is_dense;
    logic signed [W_ACC-1:0]  w_shr, w_red, w_acc_c;
    logic signed [W_ACC:0]    w_fb, w_s;
    logic signed [W_ACC+1:0]  w_nacc, w_val;
    logic signed [W_OUT-1:0]  w_clamp, w_nl;
    logic                     w_sat;

    assign w_ps       = r_side[L];
    assign w_is_sum   = (w_ps.mode == 2'd0) || (w_ps.mode == 2'd3);
    assign w_is_dense = (w_ps.mode == 2'd1);
    assign w_shr      = r_tree[NT-1] >>> FRAC;
    assign w_red      = ((w_ps.mode == 2'd2) && w_ps.allm) ? '0 : w_shr;
    assign w_fb       = (w_is_sum && w_ps.fb_en) ? (W_ACC+1)'($signed(w_ps.fb_data)) : '0;
    assign w_s        = (W_ACC+1)'(w_red) + w_fb;
    assign w_nacc     = (W_ACC+2)'(r_acc) + (W_ACC+2)'(w_s);

    always_comb begin
        w_acc_c = W_ACC'(w_nacc);
        if (w_nacc > ACC_HI)      w_acc_c = W_ACC'(ACC_HI);
        else if (w_nacc < ACC_LO) w_acc_c = W_ACC'(ACC_LO);

        w_val   = w_is_dense ? (W_ACC+2)'(w_acc_c) : (W_ACC+2)'(w_s);
        w_sat   = 1'b1;
        if (w_val > OUT_HI)      w_clamp = W_OUT'(OUT_HI);
        else if (w_val < OUT_LO) w_clamp = W_OUT'(OUT_LO);
        else begin
            w_clamp = W_OUT'(w_val);
            w_sat   = 1'b0;
        end

        // Nonlinearity sees the clamped value.
        w_nl = w_clamp;
        if (w_clamp < 0) begin
            if (w_ps.nl == 2'd1)      w_nl = '0;
            else if (w_ps.nl == 2'd2) w_nl = w_clamp >>> 3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_ov       <= 1'b0;
            r_od       <= '0;
            r_os       <= 1'b0;
            r_acc      <= '0;
            r_pend     <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[L-1:0], bus.in_valid};
            r_ov       <= 1'b0;
            if (r_vld_pipe[L]) begin
                if (w_is_dense) begin
                    r_acc  <= w_ps.last ? '0 : w_acc_c;
                    r_pend <= !w_ps.last;
                end
                if (!w_is_dense || w_ps.last) begin
                    r_ov <= 1'b1;
                    r_od <= w_nl;
                    r_os <= w_sat;
                end
            end
        end
    end

    assign bus.out_valid = r_ov;
    assign bus.out_data  = r_od;
    assign bus.out_sat   = r_os;
    assign bus.busy      = (|r_vld_pipe) || r_ov || r_pend;
endmodule

// File: doc/pe_reduce.md
PE_REDUCE -- requirements
Module: pe_reduce

Interface
REQ-001 Parameter N_LANES, default 16, number of input lanes; SHALL be a power of two >= 2; L = log2(N_LANES).
REQ-002 Parameter W_IN, default 16, signed lane width.
REQ-003 Parameter W_ACC, default 32, signed internal/accumulator width; SHALL satisfy W_ACC >= W_IN+L+2.
REQ-004 Parameter W_OUT, default 16, signed output width.
REQ-005 Parameter FRAC, default 0, arithmetic right shift applied to each reduced sum.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-010 in_data  in  N_LANES*W_IN  signed lane values; lane i at bits [i*W_IN +: W_IN].
REQ-011 in_mask  in  N_LANES  1 = lane participates.
REQ-012 mode  in  2  0 = sum, 1 = dense accumulate, 2 = max, 3 = reserved (treated as sum).
REQ-013 fb_enable / fb_data  in  1 / W_OUT  add signed partial-sum feedback (sum mode only).
REQ-014 acc_last  in  1  dense mode: final beat of accumulation.
REQ-015 nl_type  in  2  0 = none, 1 = ReLU, 2 = leaky ReLU (x>>>3), 3 = none.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 out_data  out  W_OUT  signed result.
REQ-018 out_sat  out  1  result was clamped; qualified by out_valid.
REQ-019 busy  out  1  any stage valid or dense accumulation pending.

Function
REQ-020 Each accepted beat SHALL capture mode, fb_enable, fb_data, acc_last and nl_type with the data; these travel with the beat through the pipeline.
REQ-021 Pipeline SHALL be: input register, L registered reduction stages, one post stage; accepted at cycle t -> out_valid at t+L+2 with no stall.
REQ-022 Global advance enable = !out_valid || out_ready; in_ready = enable && !rst; all stages hold when enable = 0.
REQ-023 Sum/dense: masked-out lanes contribute 0; values sign-extended to W_ACC before adding.
REQ-024 Max: masked-out lanes SHALL be treated as -2^(W_ACC-1); if all lanes are masked, the result SHALL be 0.
REQ-025 Post stage: s = reduced >>> FRAC (floor); sum mode with fb_enable adds sign-extended fb_data; fb_enable SHALL be ignored in dense and max modes.
REQ-026 Dense: s SHALL be added to acc (W_ACC, clamped at W_ACC bounds); a non-last beat SHALL produce no output; a last beat SHALL output acc+s and clear acc to 0 in the same cycle.
REQ-027 Sum and max beats SHALL neither read nor modify acc; interleaving them between dense beats SHALL be legal.
REQ-028 Saturation: value clamped to [-2^(W_OUT-1), 2^(W_OUT-1)-1]; out_sat = 1 iff clamped; the nonlinearity SHALL be applied after the clamp.
REQ-029 Output order SHALL equal acceptance order; no beat lost or duplicated under any out_ready pattern.
REQ-030 out_data and out_sat SHALL hold stable while out_valid && !out_ready.

Reset
REQ-031 With rst high at an edge: all stage valids, out_valid, out_data, out_sat, acc and the pending flag SHALL become 0; in_ready SHALL be 0 while rst is high.
REQ-032 Reset mid-operation SHALL discard all in-flight beats and any partial dense sum; first accept is possible on the first edge after rst falls.

Verification (N_LANES=4, W_IN=16, W_ACC=32, W_OUT=16, FRAC=0, out_ready=1 unless stated)
REQ-033 Sum: lanes {1,2,3,4}, mask 1111, accepted at cycle t -> out_data=10 at t+4, out_sat=0.
REQ-034 Feedback+ReLU: lanes {-5,0,0,0}, fb_data=2, fb_enable=1, nl_type=1 -> out_data=0; same with nl_type=2 -> out_data=-1.
REQ-035 Saturation: lanes {30000,30000,30000,30000} -> out_data=32767, out_sat=1; all -30000 -> -32768, out_sat=1.
REQ-036 Dense: beats summing 10, 20, -5, last on the third -> exactly one output 25; next single last beat summing 7 -> 7; rst asserted after the first beat of a new sequence -> subsequent last beat summing 3 -> 3.
REQ-037 Max: lanes {-7,100,-3,50}, mask 0101 -> -3; mask 0000 -> 0.
REQ-038 Backpressure: 8 back-to-back beats (values 1..8), out_ready low for 5 cycles mid-stream -> outputs 1..8 in order, in_ready low during the stall, out_data stable while stalled.
